// File: rtl/song_controller.sv
// Song playback controller: divides the clock into ticks and note strobes and runs a play/pause/stop FSM with loop counting.
// Optional single-step in PAUSE is built only when SONG_CTRL_STEP_EN is defined.
module song_controller #(
  parameter int TICK_DIV = 416667,
  parameter int LOOP_LEN = 14
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_play,
  input  logic       i_pause,
  input  logic       i_stop,
  input  logic       i_step,
  input  logic [7:0] i_tempo,
  input  logic [3:0] i_loops,
  output logic       o_tick_stb,
  output logic       o_note_stb,
  output logic       o_seq_restart,
  output logic       o_mute,
  output logic [1:0] o_state,
  output logic       o_done
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int POS_W = (LOOP_LEN > 1) ? $clog2(LOOP_LEN) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(LOOP_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_reg;
  logic [7:0]       tick_reg;
  logic [7:0]       tempo_reg;
  logic [POS_W-1:0] pos_reg;
  logic [3:0]       loop_reg;

  logic       tick_stb_reg, note_stb_reg, restart_reg, done_reg, mute_reg;
  logic [7:0] tempo_in;
  logic       run, tick_ev, note_ev, wrap_ev, finish_ev, step_ev;
  logic       enter_play, to_idle;

`ifdef SONG_CTRL_STEP_EN
  // A step is only honoured when no other command competes for the cycle.
  assign step_ev = (state_reg == PAUSE) && i_step && !i_stop && !i_pause && !i_play;
`else
  logic unused_step;
  assign unused_step = i_step;
  assign step_ev     = 1'b0;
`endif

  // A pause or stop sampled this cycle freezes the divider immediately, so no strobe escapes into PAUSE.
  assign tempo_in  = (i_tempo == 8'd0) ? 8'd1 : i_tempo;
  assign run       = (state_reg == PLAY) && !i_stop && !i_pause;
  assign tick_ev   = run && (div_reg == DIV_LAST);
  assign note_ev   = (tick_ev && (tick_reg == tempo_reg - 8'd1)) || step_ev;
  assign wrap_ev   = note_ev && (pos_reg == POS_LAST);
  assign finish_ev = wrap_ev && (i_loops != 4'd0) &&
                     (({1'b0, loop_reg} + 5'd1) >= {1'b0, i_loops});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    enter_play = 1'b0;
    to_idle    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_play && !i_stop && !i_pause) state_next = PLAY;
      end
      PLAY: begin
        if (i_stop)         state_next = IDLE;
        else if (i_pause)   state_next = PAUSE;
        else if (finish_ev) state_next = IDLE;
      end
      PAUSE: begin
        if (i_stop)                  state_next = IDLE;
        else if (i_play && !i_pause) state_next = PLAY;
        else if (finish_ev)          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    enter_play = (state_reg == IDLE) && (state_next == PLAY);
    to_idle    = (state_reg != IDLE) && (state_next == IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tick_stb_reg <= 1'b0;
      note_stb_reg <= 1'b0;
      restart_reg  <= 1'b0;
      done_reg     <= 1'b0;
      mute_reg     <= 1'b1;
      div_reg      <= '0;
      tick_reg     <= 8'd0;
      tempo_reg    <= 8'd1;
      pos_reg      <= '0;
      loop_reg     <= 4'd0;
    end else begin
      tick_stb_reg <= tick_ev || step_ev;
      note_stb_reg <= note_ev;
      restart_reg  <= enter_play || to_idle;
      done_reg     <= finish_ev;
      mute_reg     <= (state_next != PLAY);
      if (state_next == IDLE) begin
        div_reg  <= '0;
        tick_reg <= 8'd0;
        pos_reg  <= '0;
        loop_reg <= 4'd0;
      end else begin
        if (run) div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
        if (note_ev) begin
          // Note boundary: restart the tick count and pick up any new tempo.
          tick_reg  <= 8'd0;
          tempo_reg <= tempo_in;
          if (pos_reg == POS_LAST) begin
            pos_reg  <= '0;
            loop_reg <= loop_reg + 4'd1;
          end else begin
            pos_reg <= pos_reg + POS_W'(1);
          end
        end else if (tick_ev) begin
          tick_reg <= tick_reg + 8'd1;
        end
        if (enter_play) tempo_reg <= tempo_in;
      end
    end
  end

  assign o_tick_stb    = tick_stb_reg;
  assign o_note_stb    = note_stb_reg;
  assign o_seq_restart = restart_reg;
  assign o_done        = done_reg;
  assign o_mute        = mute_reg;
  assign o_state       = state_reg;

endmodule

// File: tb/tb_song_controller.sv
// Directed self-checking bench for song_controller (TICK_DIV=4, LOOP_LEN=3).
// Step checks follow SONG_CTRL_STEP_EN when the bench is built with it.
module tb_song_controller;
  localparam int TD = 4;
  localparam int LL = 3;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_play = 1'b0, i_pause = 1'b0, i_stop = 1'b0, i_step = 1'b0;
  logic [7:0] i_tempo = 8'd2;
  logic [3:0] i_loops = 4'd0;
  logic       o_tick_stb, o_note_stb, o_seq_restart, o_mute, o_done;
  logic [1:0] o_state;

  int vecs = 0;
  int errs = 0;

  song_controller #(.TICK_DIV(TD), .LOOP_LEN(LL)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_play(i_play), .i_pause(i_pause),
    .i_stop(i_stop), .i_step(i_step), .i_tempo(i_tempo), .i_loops(i_loops),
    .o_tick_stb(o_tick_stb), .o_note_stb(o_note_stb), .o_seq_restart(o_seq_restart),
    .o_mute(o_mute), .o_state(o_state), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_play();
    i_play = 1'b1; cyc(); i_play = 1'b0;
  endtask

  task automatic pulse_stop();
    i_stop = 1'b1; cyc(); i_stop = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    vecs++;
    if ({o_state, o_mute, o_tick_stb, o_note_stb, o_seq_restart, o_done} !== 7'b00_1_0000) begin
      errs++;
      $display("FAIL reset_vals got %b exp 0010000",
               {o_state, o_mute, o_tick_stb, o_note_stb, o_seq_restart, o_done});
    end
    i_rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      vecs++;
      if ({o_state, o_mute, o_tick_stb} !== 4'b00_1_0) begin
        errs++;
        $display("FAIL post_reset_idle c=%0d got %b exp 0010", c, {o_state, o_mute, o_tick_stb});
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_tick_note();
    logic [2:0] exp;
    i_tempo = 8'd2; i_loops = 4'd0;
    pulse_play();
    vecs++;
    if ({o_state, o_seq_restart, o_mute} !== 4'b01_1_0) begin
      errs++;
      $display("FAIL play_entry got %b exp 0110", {o_state, o_seq_restart, o_mute});
    end
    for (int c = 1; c <= 16; c++) begin
      cyc();
      exp = {(c % TD) == 0, (c % (2 * TD)) == 0, 1'b0};
      vecs++;
      if ({o_tick_stb, o_note_stb, o_seq_restart} !== exp) begin
        errs++;
        $display("FAIL tick_note c=%0d got %b exp %b", c, {o_tick_stb, o_note_stb, o_seq_restart}, exp);
      end
    end
    pulse_stop();
    vecs++;
    if ({o_state, o_seq_restart, o_mute} !== 4'b00_1_1) begin
      errs++;
      $display("FAIL stop_restart got %b exp 0011", {o_state, o_seq_restart, o_mute});
    end
    $display("test_tick_note done");
  endtask

  task automatic test_loops();
    logic [3:0] exp;
    int notes;
    notes = 0;
    i_tempo = 8'd1; i_loops = 4'd2;
    pulse_play();
    for (int c = 1; c <= 30; c++) begin
      cyc();
      if (o_note_stb) notes++;
      exp = {((c % TD) == 0) && (c <= 6 * TD), ((c % TD) == 0) && (c <= 6 * TD),
             c == 6 * TD, c == 6 * TD};
      vecs++;
      if ({o_tick_stb, o_note_stb, o_done, o_seq_restart} !== exp) begin
        errs++;
        $display("FAIL loops c=%0d got %b exp %b", c, {o_tick_stb, o_note_stb, o_done, o_seq_restart}, exp);
      end
      if (c > 6 * TD) begin
        vecs++;
        if ({o_state, o_mute} !== 3'b00_1) begin
          errs++;
          $display("FAIL loops_idle c=%0d got %b exp 001", c, {o_state, o_mute});
        end
      end
    end
    vecs++;
    if (notes != 6) begin
      errs++;
      $display("FAIL note_count got %0d exp 6", notes);
    end
    i_loops = 4'd0;
    $display("test_loops done");
  endtask

  task automatic test_pause();
    logic [1:0] exp;
    i_tempo = 8'd2;
    pulse_play();
    for (int c = 1; c <= 13; c++) begin
      cyc();
      exp = {(c % TD) == 0, (c % (2 * TD)) == 0};
      vecs++;
      if ({o_tick_stb, o_note_stb} !== exp) begin
        errs++;
        $display("FAIL pre_pause c=%0d got %b exp %b", c, {o_tick_stb, o_note_stb}, exp);
      end
    end
    i_pause = 1'b1; cyc(); i_pause = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) cyc();
      vecs++;
      if ({o_state, o_mute, o_tick_stb, o_note_stb} !== 5'b10_1_00) begin
        errs++;
        $display("FAIL paused c=%0d got %b exp 10100", c, {o_state, o_mute, o_tick_stb, o_note_stb});
      end
    end
    pulse_play();
    vecs++;
    if ({o_state, o_seq_restart, o_tick_stb} !== 4'b01_0_0) begin
      errs++;
      $display("FAIL resume got %b exp 0100", {o_state, o_seq_restart, o_tick_stb});
    end
    for (int k = 1; k <= TD; k++) begin
      cyc();
      exp = {k == TD - (13 % TD), k == TD - (13 % TD)};
      vecs++;
      if ({o_tick_stb, o_note_stb} !== exp) begin
        errs++;
        $display("FAIL post_resume k=%0d got %b exp %b", k, {o_tick_stb, o_note_stb}, exp);
      end
    end
    pulse_stop();
    $display("test_pause done");
  endtask

  task automatic test_stop_all();
    logic [2:0] exp;
    i_tempo = 8'd1; i_loops = 4'd0;
    pulse_play();
    repeat (6) cyc();
    i_stop = 1'b1; i_pause = 1'b1; i_play = 1'b1;
    cyc();
    i_stop = 1'b0; i_pause = 1'b0; i_play = 1'b0;
    vecs++;
    if ({o_state, o_seq_restart, o_mute, o_tick_stb, o_note_stb} !== 6'b00_1_1_00) begin
      errs++;
      $display("FAIL stop_all got %b exp 001100",
               {o_state, o_seq_restart, o_mute, o_tick_stb, o_note_stb});
    end
    repeat (3) cyc();
    i_loops = 4'd1;
    pulse_play();
    for (int c = 1; c <= 14; c++) begin
      cyc();
      exp = {((c % TD) == 0) && (c <= LL * TD), ((c % TD) == 0) && (c <= LL * TD), c == LL * TD};
      vecs++;
      if ({o_tick_stb, o_note_stb, o_done} !== exp) begin
        errs++;
        $display("FAIL cleared_counters c=%0d got %b exp %b", c, {o_tick_stb, o_note_stb, o_done}, exp);
      end
    end
    i_loops = 4'd0;
    $display("test_stop_all done");
  endtask

  task automatic test_tempo_change();
    logic [1:0] exp;
    i_tempo = 8'd2;
    pulse_play();
    for (int c = 1; c <= 16; c++) begin
      cyc();
      if (c == 5) i_tempo = 8'd0;
      exp = {(c % TD) == 0, (c == 8) || (c == 12) || (c == 16)};
      vecs++;
      if ({o_tick_stb, o_note_stb} !== exp) begin
        errs++;
        $display("FAIL tempo_change c=%0d got %b exp %b", c, {o_tick_stb, o_note_stb}, exp);
      end
    end
    pulse_stop();
    i_tempo = 8'd2;
    $display("test_tempo_change done");
  endtask

  task automatic test_async_reset();
    i_tempo = 8'd1;
    pulse_play();
    repeat (TD) cyc();
    vecs++;
    if ({o_tick_stb, o_note_stb} !== 2'b11) begin
      errs++;
      $display("FAIL strobe_before_rst got %b exp 11", {o_tick_stb, o_note_stb});
    end
    #3 i_rst = 1'b1;
    #1;
    vecs++;
    if ({o_state, o_mute, o_tick_stb, o_note_stb, o_seq_restart, o_done} !== 7'b00_1_0000) begin
      errs++;
      $display("FAIL async_rst got %b exp 0010000",
               {o_state, o_mute, o_tick_stb, o_note_stb, o_seq_restart, o_done});
    end
    cyc();
    i_rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      vecs++;
      if ({o_state, o_tick_stb} !== 3'b00_0) begin
        errs++;
        $display("FAIL rst_release_idle c=%0d got %b exp 000", c, {o_state, o_tick_stb});
      end
    end
    $display("test_async_reset done");
  endtask

  task automatic test_step();
    logic [1:0] exp;
    i_tempo = 8'd2;
    pulse_play();
    repeat (5) cyc();
    i_pause = 1'b1; cyc(); i_pause = 1'b0;
    i_step = 1'b1; cyc(); i_step = 1'b0;
`ifdef SONG_CTRL_STEP_EN
    exp = 2'b11;
`else
    exp = 2'b00;
`endif
    vecs++;
    if ({o_tick_stb, o_note_stb, o_state} !== {exp, 2'b10}) begin
      errs++;
      $display("FAIL step_strobe got %b exp %b", {o_tick_stb, o_note_stb, o_state}, {exp, 2'b10});
    end
    cyc();
    vecs++;
    if ({o_tick_stb, o_note_stb} !== 2'b00) begin
      errs++;
      $display("FAIL step_single got %b exp 00", {o_tick_stb, o_note_stb});
    end
    pulse_play();
    for (int k = 1; k <= TD; k++) begin
      cyc();
`ifdef SONG_CTRL_STEP_EN
      exp = {k == 3, 1'b0};
`else
      exp = {k == 3, k == 3};
`endif
      vecs++;
      if ({o_tick_stb, o_note_stb} !== exp) begin
        errs++;
        $display("FAIL step_resume k=%0d got %b exp %b", k, {o_tick_stb, o_note_stb}, exp);
      end
    end
    pulse_stop();
    $display("test_step done");
  endtask

  initial begin
    test_reset();
    test_tick_note();
    test_loops();
    test_pause();
    test_stop_all();
    test_tempo_change();
    test_async_reset();
    test_step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
